// File: rtl/fix_mac_accum.sv
// Accumulates a programmed number of signed products into a guarded accumulator,
// then rescales and saturates to OUT_WIDTH bits. Define FIX_MAC_ROUND_EN for round-half-up.
module fix_mac_accum #(
    parameter int PROD_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  prod_valid,
    input  logic [PROD_WIDTH-1:0] prod_data,
    output logic                  prod_ready,
    output logic                  out_valid,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2**(OUT_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

    state_t                 state, state_next;
    logic [ACC_WIDTH-1:0]   acc, acc_next;
    logic [LEN_WIDTH-1:0]   count;
    logic                   beat, last_beat;
    logic signed [ACC_WIDTH:0] ext, rnd, shf;
    logic [OUT_WIDTH-1:0]   res_data;
    logic                   res_sat;

    assign beat      = prod_valid && (state == ACCUM);
    assign last_beat = beat && (count == LEN_WIDTH'(1));
    assign acc_next  = acc + {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};

    // Rescale is evaluated on the post-add value so DONE can latch it on entry.
    always_comb begin
        ext = {acc_next[ACC_WIDTH-1], acc_next};
`ifdef FIX_MAC_ROUND_EN
        rnd = ext + (ACC_WIDTH+1)'(2**(FRAC_SHIFT-1));
`else
        rnd = ext;
`endif
        shf = rnd >>> FRAC_SHIFT;
        if (shf > SAT_MAX) begin
            res_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            res_sat  = 1'b1;
        end else if (shf < SAT_MIN) begin
            res_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            res_sat  = 1'b1;
        end else begin
            res_data = shf[OUT_WIDTH-1:0];
            res_sat  = 1'b0;
        end
    end

    // NOTE: every signal written in this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        prod_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = (len != '0) ? ACCUM : DONE;
            end
            ACCUM: begin
                prod_ready = 1'b1;
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        if (len != '0) begin
                            count <= len;
                        end else begin
                            out_data <= '0;
                            out_sat  <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= acc_next;
                        count <= count - LEN_WIDTH'(1);
                    end
                    if (last_beat) begin
                        out_data <= res_data;
                        out_sat  <= res_sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_mac_accum.sv
// Self-checking bench for fix_mac_accum: table-driven jobs with a result scoreboard,
// plus hand-written stall and mid-job reset sequences. Honours FIX_MAC_ROUND_EN.
module tb_fix_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        prod_valid;
    logic [31:0] prod_data;
    logic        prod_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [7:0]       len;
        logic [3:0][31:0] beats;
        logic [3:0]       gap;
        logic [15:0]      exp_d;
        logic             exp_s;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
    } res_t;

`ifdef FIX_MAC_ROUND_EN
    localparam logic [15:0] EXP_500 = 16'd2;
    localparam logic [15:0] EXP_68K = 16'd266;
`else
    localparam logic [15:0] EXP_500 = 16'd1;
    localparam logic [15:0] EXP_68K = 16'd265;
`endif

    vec_t vecs[7];
    res_t sb[$];

    fix_mac_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .prod_ready (prod_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input vec_t v);
        res_t r;
        int   waited;
        sb.push_back('{d: v.exp_d, s: v.exp_s});
        start = 1'b1;
        len   = v.len;
        tick();
        start = 1'b0;
        for (int b = 0; b < int'(v.len); b++) begin
            repeat (int'(v.gap)) tick();
            prod_valid = 1'b1;
            prod_data  = v.beats[b];
            if (b == 0) check("prod_ready_accum", 32'(prod_ready), 32'd1);
            tick();
            prod_valid = 1'b0;
        end
        check("valid_latency", 32'(out_valid), 32'd1);
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        r = sb.pop_front();
        check("out_data", 32'(out_data), 32'(r.d));
        check("out_sat", 32'(out_sat), 32'(r.s));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_accept", {30'd0, out_valid, busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{len: 8'd1, beats: {32'd0, 32'd0, 32'd0, 32'sd500}, gap: 4'd0,
                    exp_d: EXP_500, exp_s: 1'b0};
        vecs[1] = '{len: 8'd2, beats: {32'd0, 32'd0, -32'sd1218000, 32'sd500}, gap: 4'd0,
                    exp_d: 16'hED6C, exp_s: 1'b0};
        vecs[2] = '{len: 8'd4, beats: {4{32'h4000_0000}}, gap: 4'd0,
                    exp_d: 16'h7FFF, exp_s: 1'b1};
        vecs[3] = '{len: 8'd2, beats: {32'd0, 32'd0, -32'sd1073709056, -32'sd1073709056},
                    gap: 4'd0, exp_d: 16'h8000, exp_s: 1'b1};
        vecs[4] = '{len: 8'd3, beats: {32'd0, 32'sd70000, -32'sd3000, 32'sd1000}, gap: 4'd0,
                    exp_d: EXP_68K, exp_s: 1'b0};
        vecs[5] = '{len: 8'd3, beats: {32'd0, 32'sd70000, -32'sd3000, 32'sd1000}, gap: 4'd2,
                    exp_d: EXP_68K, exp_s: 1'b0};
        vecs[6] = '{len: 8'd0, beats: '0, gap: 4'd0, exp_d: 16'h0000, exp_s: 1'b0};

        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        prod_valid = 1'b0;
        prod_data  = '0;
        out_ready  = 1'b0;
        #12;
        check("reset_outputs", {13'd0, prod_ready, out_valid, out_sat, busy, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Output stall: result held, no product accepted, start ignored.
        vecs[0].exp_d = EXP_500;
        start = 1'b1;
        len   = 8'd1;
        tick();
        start      = 1'b0;
        prod_valid = 1'b1;
        prod_data  = 32'sd500;
        tick();
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            len   = 8'd5;
            check("stall_data", 32'(out_data), 32'(EXP_500));
            check("stall_ready_valid", {30'd0, prod_ready, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("start_ignored_in_done", 32'(busy), 32'd0);
        start      = 1'b0;
        prod_valid = 1'b0;
        tick();

        // Mid-job reset: abort, then a clean job.
        start = 1'b1;
        len   = 8'd4;
        tick();
        start      = 1'b0;
        prod_valid = 1'b1;
        prod_data  = 32'h4000_0000;
        tick();
        tick();
        prod_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {13'd0, prod_ready, out_valid, out_sat, busy, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_job(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fix_mac_accum.md
Name: fix_mac_accum

Overview:
- Downstream consumer of the 16x16 signed fixed-point multiplier. It accumulates a programmed number of 32-bit signed products into a guarded accumulator.
- It then rescales the sum back to the 16-bit fixed-point format, with saturation, and presents one result per job on a valid/ready output.
- Typical use: dot-product / FIR tap summation in the datapath.

Parameters:
- PROD_WIDTH, 32, width of incoming signed product (2x operand width).
- ACC_WIDTH, 40, accumulator width. Guard bits = ACC_WIDTH-PROD_WIDTH; must be >= LEN_WIDTH.
- OUT_WIDTH, 16, width of saturated signed result.
- FRAC_SHIFT, 8, arithmetic right shift applied to the accumulator (fraction bits of operand format).
- LEN_WIDTH, 8, width of job length field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  job start pulse; accepted only in IDLE.
- len  input  LEN_WIDTH  number of products in job; sampled with start.
- prod_valid  input  1  product beat valid.
- prod_data  input  PROD_WIDTH  signed product (two's complement).
- prod_ready  output  1  block accepts a product this cycle.
- out_valid  output  1  result valid.
- out_data  output  OUT_WIDTH  signed saturated result.
- out_sat  output  1  result was clipped; qualified by out_valid.
- out_ready  input  1  downstream accepts result.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync deassert by clk domain): state=IDLE, acc=0, count=0. prod_ready, out_valid, out_data, out_sat and busy all 0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - prod_ready=0.
  - start=1 and len!=0: acc<=0, count<=len, go to ACCUM.
  - start=1 and len==0: acc<=0, go to DONE. Result is 0, out_sat=0.
- ACCUM:
  - prod_ready=1.
  - Each beat with prod_valid&&prod_ready: acc <= acc + sign-extended prod_data, count <= count-1.
  - On the beat where count==1: go to DONE.
  - prod_valid low inserts stalls; acc and count hold.
- DONE:
  - out_valid=1; out_data/out_sat registered on entry and held stable until out_ready=1.
  - prod_ready=0.
  - out_valid&&out_ready: go to IDLE, out_valid<=0 next cycle.
- Latency: out_valid asserts the cycle after the last accepted product. Throughput is one product per cycle.
- Rescale: s = acc >>> FRAC_SHIFT (arithmetic), then rounding per the optional feature.
  - s > 2^(OUT_WIDTH-1)-1 gives 32767 with out_sat=1.
  - s < -2^(OUT_WIDTH-1) gives -32768 with out_sat=1.
  - Otherwise out_data = s[OUT_WIDTH-1:0] with out_sat=0.
- Accumulator never overflows for len <= 2^LEN_WIDTH-1 with default widths. No wrap detection is required.
- start while busy=1 is ignored, including in the DONE cycle where out_ready=1. Back-to-back jobs need start in IDLE.
- prod_valid in IDLE/DONE is not consumed (prod_ready=0). Upstream must hold data.
- Reset asserted mid-job aborts immediately to reset values; no partial result is emitted.

Optional Feature:
- Macro FIX_MAC_ROUND_EN.
- Defined: round-half-up before the shift, s = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed in ACC_WIDTH+1 bits so the addition cannot wrap. Saturation is then applied to the rounded value.
- Undefined: truncation, i.e. plain arithmetic shift (floor).
- Interface and timing are identical in both builds.

Test Plan:
- Single product: len=1, prod_data=500 (100*5). Truncation build gives out_data=1; ROUND_EN build gives 2. out_sat=0, out_valid 1 cycle after the beat.
- Negative product: len=2, beats 500 and -1218000 (0xC090*75). Sum -1217500 gives out_data=-4756 (0xED6C) in both builds.
- Positive saturation: len=4, each beat 0x4000_0000 (-32768*-32768). Expect out_data=32767 (0x7FFF), out_sat=1.
- Negative saturation: len=2, each beat -1073709056 (32767*-32768). Expect out_data=-32768 (0x8000), out_sat=1.
- Handshake/stalls:
  - len=3 with prod_valid gaps of 2 cycles: same result as gap-free.
  - out_ready held low 5 cycles: out_data stable, prod_ready=0, start ignored.
- Edge cases:
  - len=0: out_data=0 one cycle after start.
  - rst_n pulsed low mid-ACCUM: all outputs 0 immediately.
  - A new job afterward returns a correct result, unaffected by the aborted job.
